// File: rtl/arm_pio_capture_in.sv
// Avalon-MM input PIO: synchronised input bus, sticky per-bit edge capture and a
// maskable interrupt (level on synced data, or edge-capture based).
module arm_pio_capture_in #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_TYPE   = 0,
  parameter int unsigned IRQ_MODE    = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic                  irq
);

  logic [DATA_WIDTH-1:0] sync_data;
  logic [DATA_WIDTH-1:0] prev_q;
  logic [DATA_WIDTH-1:0] irqmask_q, irqmask_d;
  logic [DATA_WIDTH-1:0] edgecap_q, edgecap_d;
  logic [DATA_WIDTH-1:0] rise, fall, det, cap_clr;
  logic [31:0]           readdata_d;
  logic                  irq_d;
  logic                  wr_en;
  logic                  unused_writedata;

  generate
    if (SYNC_STAGES == 0) begin : g_bypass
      assign sync_data = in_port;
    end else begin : g_sync
      logic [DATA_WIDTH-1:0] stage_q [SYNC_STAGES];

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < SYNC_STAGES; i++) stage_q[i] <= '0;
        end else begin
          stage_q[0] <= in_port;
          for (int i = 1; i < SYNC_STAGES; i++) stage_q[i] <= stage_q[i-1];
        end
      end

      assign sync_data = stage_q[SYNC_STAGES-1];
    end
  endgenerate

  // Upper writedata bits are ignored when DATA_WIDTH < 32.
  assign unused_writedata = ^writedata;

  always_comb begin
    rise = sync_data & ~prev_q;
    fall = ~sync_data & prev_q;
    if (EDGE_TYPE == 0) begin
      det = rise;
    end else if (EDGE_TYPE == 1) begin
      det = fall;
    end else begin
      det = rise | fall;
    end

    wr_en     = chipselect & ~write_n;
    irqmask_d = irqmask_q;
    cap_clr   = '0;
    if (wr_en && (address == 2'd2)) irqmask_d = writedata[DATA_WIDTH-1:0];
    if (wr_en && (address == 2'd3)) cap_clr = writedata[DATA_WIDTH-1:0];

    // A new event in the clearing cycle survives the clear.
    edgecap_d = (edgecap_q & ~cap_clr) | det;

    if (IRQ_MODE == 0) begin
      irq_d = |(sync_data & irqmask_q);
    end else begin
      irq_d = |(edgecap_q & irqmask_q);
    end

    readdata_d = '0;
    unique case (address)
      2'd0: readdata_d[DATA_WIDTH-1:0] = sync_data;
      2'd1: readdata_d = '0;
      2'd2: readdata_d[DATA_WIDTH-1:0] = irqmask_q;
      2'd3: readdata_d[DATA_WIDTH-1:0] = edgecap_q;
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q    <= '0;
      irqmask_q <= '0;
      edgecap_q <= '0;
      irq       <= 1'b0;
      readdata  <= '0;
    end else begin
      prev_q    <= sync_data;
      irqmask_q <= irqmask_d;
      edgecap_q <= edgecap_d;
      irq       <= irq_d;
      readdata  <= readdata_d;
    end
  end

endmodule

// File: tb/tb_arm_pio_capture_in.sv
// Directed bench: default instance (rising edge, edge-capture irq) plus an
// any-edge / level-irq instance sharing the bus.
module tb_arm_pio_capture_in;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata, readdata2;
  logic [15:0] in_port, in_port2;
  logic        irq, irq2;

  int nvec  = 0;
  int nfail = 0;

  arm_pio_capture_in dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .irq        (irq)
  );

  arm_pio_capture_in #(
    .DATA_WIDTH  (16),
    .SYNC_STAGES (2),
    .EDGE_TYPE   (2),
    .IRQ_MODE    (0)
  ) dut2 (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata2),
    .in_port    (in_port2),
    .irq        (irq2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] in_val;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [31:0] wr_data;
    logic [1:0]  rd_addr;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v, output logic [31:0] v2);
    address    = a;
    chipselect = 1'b1;
    tick();
    v          = readdata;
    v2         = readdata2;
    chipselect = 1'b0;
  endtask

  initial begin
    logic [31:0] got, got2;
    logic        exp_irq2 [7];

    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = '0;
    in_port2   = '0;

    vecs[0] = '{16'hA5C3, 1'b0, 2'd0, 32'h0,         2'd0, 32'h0000A5C3};
    vecs[1] = '{16'hA5C3, 1'b0, 2'd0, 32'h0,         2'd1, 32'h0};
    vecs[2] = '{16'hA5C3, 1'b1, 2'd1, 32'hFFFFFFFF,  2'd1, 32'h0};
    vecs[3] = '{16'hA5C3, 1'b1, 2'd0, 32'h00001234,  2'd0, 32'h0000A5C3};
    vecs[4] = '{16'hA5C3, 1'b1, 2'd2, 32'hFFFF0010,  2'd2, 32'h00000010};
    vecs[5] = '{16'h0000, 1'b1, 2'd2, 32'h0,         2'd2, 32'h0};
    vecs[6] = '{16'h5A3C, 1'b0, 2'd0, 32'h0,         2'd0, 32'h00005A3C};
    vecs[7] = '{16'h5A3C, 1'b0, 2'd0, 32'h0,         2'd3, 32'h0000FFFF};
    vecs[8] = '{16'h5A3C, 1'b1, 2'd3, 32'h0000FFFF,  2'd3, 32'h0};
    vecs[9] = '{16'h0000, 1'b0, 2'd0, 32'h0,         2'd3, 32'h0};

    #1;
    check("reset_readdata", readdata, 32'h0);
    check("reset_irq", {31'h0, irq}, 32'h0);
    check("reset_readdata2", readdata2, 32'h0);
    check("reset_irq2", {31'h0, irq2}, 32'h0);
    #11 reset_n = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      in_port = vecs[i].in_val;
      if (vecs[i].wr_en) wr(vecs[i].wr_addr, vecs[i].wr_data);
      repeat (4) tick();
      rd(vecs[i].rd_addr, got, got2);
      check($sformatf("vec%0d_read", i), got, vecs[i].exp_rd);
    end

    // Rising capture and irq latency on bit 0.
    wr(2'd2, 32'h1);
    wr(2'd3, 32'hFFFF);
    repeat (4) tick();
    in_port = 16'h0001;
    tick();
    check("rise_irq_n0", {31'h0, irq}, 32'h0);
    tick();
    check("rise_irq_n1", {31'h0, irq}, 32'h0);
    tick();
    check("rise_irq_n2", {31'h0, irq}, 32'h0);
    tick();
    check("rise_irq_n3", {31'h0, irq}, 32'h1);
    rd(2'd3, got, got2);
    check("rise_edgecap", got, 32'h1);
    wr(2'd3, 32'h1);
    check("clr_irq_same_edge", {31'h0, irq}, 32'h1);
    tick();
    check("clr_irq_next", {31'h0, irq}, 32'h0);

    // Clear of all bits in the cycle bit 3's rising edge is detected.
    in_port = 16'h0009;
    tick();
    tick();
    wr(2'd3, 32'hFFFF);
    rd(2'd3, got, got2);
    check("collision_edgecap", got, 32'h8);
    check("collision_irq", {31'h0, irq}, 32'h0);

    // Mask gating of a pending capture.
    wr(2'd2, 32'h0);
    wr(2'd3, 32'hFFFF);
    in_port = 16'h0019;
    repeat (4) tick();
    rd(2'd3, got, got2);
    check("mask_edgecap", got, 32'h10);
    check("mask_irq_off", {31'h0, irq}, 32'h0);
    wr(2'd2, 32'hABCD0010);
    tick();
    check("mask_irq_on", {31'h0, irq}, 32'h1);
    rd(2'd2, got, got2);
    check("mask_readback", got, 32'h10);

    // Any-edge capture and level irq on the second instance.
    wr(2'd2, 32'h4);
    wr(2'd3, 32'hFFFF);
    repeat (2) tick();
    exp_irq2 = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    in_port2 = 16'h0004;
    for (int k = 0; k < 7; k++) begin
      tick();
      if (k == 2) in_port2 = 16'h0000;
      check($sformatf("level_irq2_c%0d", k), {31'h0, irq2}, {31'h0, exp_irq2[k]});
    end
    rd(2'd3, got, got2);
    check("any_edgecap2", got2, 32'h4);
    wr(2'd3, 32'h4);
    in_port2 = 16'h0004;
    repeat (4) tick();
    wr(2'd3, 32'h4);
    repeat (2) tick();
    rd(2'd3, got, got2);
    check("any_cleared2", got2, 32'h0);
    in_port2 = 16'h0000;
    repeat (4) tick();
    rd(2'd3, got, got2);
    check("fall_edgecap2", got2, 32'h4);

    // Asynchronous reset in the middle of traffic.
    in_port = 16'h0000;
    repeat (4) tick();
    wr(2'd3, 32'hFFFF);
    wr(2'd2, 32'hFF);
    in_port = 16'h00FF;
    repeat (4) tick();
    rd(2'd3, got, got2);
    check("pre_reset_edgecap", got, 32'hFF);
    check("pre_reset_irq", {31'h0, irq}, 32'h1);
    address    = 2'd3;
    chipselect = 1'b1;
    in_port    = 16'hFF00;
    #3 reset_n = 1'b0;
    #1;
    check("async_reset_readdata", readdata, 32'h0);
    check("async_reset_irq", {31'h0, irq}, 32'h0);
    chipselect = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 reset_n = 1'b1;
    rd(2'd3, got, got2);
    check("post_reset_edgecap", got, 32'h0);
    rd(2'd2, got, got2);
    check("post_reset_mask", got, 32'h0);
    repeat (3) tick();
    rd(2'd3, got, got2);
    check("held_high_rise", got, 32'hFF00);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
